// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: result-source select, load funct3
// encodings and the FSM state encoding.
package wb_pkg;

   typedef enum logic [1:0] {
      SEL_ALU  = 2'd0,
      SEL_LOAD = 2'd1,
      SEL_PC4  = 2'd2,
      SEL_CSR  = 2'd3
   } rd_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_LD = 2'd1,
      ST_DRAIN   = 2'd2
   } wb_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_load_stage_if.sv
// MEM -> WB handshake bundle: instruction fields presented by the MEM stage
// and the ready returned by the write-back stage.
interface wb_load_stage_if
   import wb_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) ();

   logic            mem_valid;
   logic            mem_ready;
   logic            mem_regwrite;
   rd_sel_e         mem_rd_sel;
   logic [2:0]      mem_funct3;
   logic [2:0]      mem_addr_lo;
   logic [XLEN-1:0] mem_alu;
   logic [XLEN-1:0] mem_pc4;
   logic [XLEN-1:0] mem_csr;
   logic [RA_W-1:0] mem_rd_addr;

   modport master (
      output mem_valid, mem_regwrite, mem_rd_sel, mem_funct3, mem_addr_lo,
             mem_alu, mem_pc4, mem_csr, mem_rd_addr,
      input  mem_ready
   );

   modport slave (
      input  mem_valid, mem_regwrite, mem_rd_sel, mem_funct3, mem_addr_lo,
             mem_alu, mem_pc4, mem_csr, mem_rd_addr,
      output mem_ready
   );

endinterface

// File: rtl/load_align.sv
// Combinational load aligner: picks the byte/half/word addressed by addr_lo
// out of the memory word and sign- or zero-extends it to XLEN.
module load_align
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] word,
   input  logic [2:0]      funct3,
   input  logic [2:0]      addr_lo,
   output logic [XLEN-1:0] data
);

   logic [2:0]  b_off;
   logic [2:0]  h_off;
   logic [2:0]  w_off;
   logic [7:0]  b_val;
   logic [15:0] h_val;
   logic [31:0] w_val;

   always_comb begin
      // byte offset wraps at the word size, so addr_lo[2] is ignored at XLEN=32
      b_off = addr_lo & 3'(XLEN / 8 - 1);
      h_off = b_off & 3'b110;
      w_off = b_off & 3'b100;
      b_val = 8'(word >> {b_off, 3'b000});
      h_val = 16'(word >> {h_off, 3'b000});
      w_val = 32'(word >> {w_off, 3'b000});

      case (funct3)
         F3_LB:   data = XLEN'($signed(b_val));
         F3_LBU:  data = XLEN'(b_val);
         F3_LH:   data = XLEN'($signed(h_val));
         F3_LHU:  data = XLEN'(h_val);
         F3_LW:   data = XLEN'($signed(w_val));
         F3_LWU:  data = XLEN'(w_val);
         default: data = word;
      endcase
   end

endmodule

// File: rtl/wb_load_stage.sv
// Write-back stage: muxes the result source, waits for load data, aligns it
// and issues a one-cycle register-file write. Counts load-wait cycles.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_IDLE    | ready; non-loads retire next cycle, loads go to WAIT_LD
//   ST_WAIT_LD | waiting for dmem_rvalid of the latched load
//   ST_DRAIN   | load was flushed; swallow its rvalid, then back to IDLE
module wb_load_stage
   import wb_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int RA_W  = 5,
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   wb_load_stage_if.slave    mem_if,
   input  logic [XLEN-1:0]   dmem_rdata,
   input  logic              dmem_rvalid,
   input  logic              flush,
   output logic              wb_regwrite,
   output logic [XLEN-1:0]   wb_rd_data,
   output logic [RA_W-1:0]   wb_rd_addr,
   output logic [CNT_W-1:0]  ld_stall_cnt
);

   wb_state_e        state_q, state_d;
   logic [2:0]       ld_funct3_q, ld_funct3_d;
   logic [2:0]       ld_addr_lo_q, ld_addr_lo_d;
   logic [RA_W-1:0]  ld_rd_q, ld_rd_d;
   logic             ld_regwrite_q, ld_regwrite_d;
   logic             wb_regwrite_q, wb_regwrite_d;
   logic [XLEN-1:0]  wb_rd_data_q, wb_rd_data_d;
   logic [RA_W-1:0]  wb_rd_addr_q, wb_rd_addr_d;
   logic [CNT_W-1:0] ld_stall_cnt_q, ld_stall_cnt_d;

   logic             accept;
   logic             is_load;
   logic [XLEN-1:0]  sel_data;
   logic [XLEN-1:0]  aligned;

   load_align #(.XLEN(XLEN)) u_align (
      .word    (dmem_rdata),
      .funct3  (ld_funct3_q),
      .addr_lo (ld_addr_lo_q),
      .data    (aligned)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (accept && is_load && !flush) state_d = ST_WAIT_LD;
         ST_WAIT_LD: begin
            if (dmem_rvalid)  state_d = ST_IDLE;
            else if (flush)   state_d = ST_DRAIN;
         end
         ST_DRAIN:   if (dmem_rvalid) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      // ready is also masked by rst so it reads 0 while reset is held
      mem_if.mem_ready = (state_q == ST_IDLE) && rst;
      accept           = mem_if.mem_valid && mem_if.mem_ready;
      is_load          = (mem_if.mem_rd_sel == SEL_LOAD);

      case (mem_if.mem_rd_sel)
         SEL_PC4: sel_data = mem_if.mem_pc4;
         SEL_CSR: sel_data = mem_if.mem_csr;
         default: sel_data = mem_if.mem_alu;
      endcase

      wb_regwrite_d  = 1'b0;
      wb_rd_data_d   = wb_rd_data_q;
      wb_rd_addr_d   = wb_rd_addr_q;
      ld_funct3_d    = ld_funct3_q;
      ld_addr_lo_d   = ld_addr_lo_q;
      ld_rd_d        = ld_rd_q;
      ld_regwrite_d  = ld_regwrite_q;
      ld_stall_cnt_d = ld_stall_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (accept && !flush) begin
               if (is_load) begin
                  ld_funct3_d   = mem_if.mem_funct3;
                  ld_addr_lo_d  = mem_if.mem_addr_lo;
                  ld_rd_d       = mem_if.mem_rd_addr;
                  ld_regwrite_d = mem_if.mem_regwrite;
               end else begin
                  wb_rd_data_d  = sel_data;
                  wb_rd_addr_d  = mem_if.mem_rd_addr;
                  wb_regwrite_d = mem_if.mem_regwrite && (mem_if.mem_rd_addr != '0);
               end
            end
         end
         ST_WAIT_LD: begin
            if (dmem_rvalid) begin
               if (!flush) begin
                  wb_rd_data_d  = aligned;
                  wb_rd_addr_d  = ld_rd_q;
                  wb_regwrite_d = ld_regwrite_q && (ld_rd_q != '0);
               end
            end else if (ld_stall_cnt_q != '1) begin
               ld_stall_cnt_d = ld_stall_cnt_q + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (!dmem_rvalid && (ld_stall_cnt_q != '1))
               ld_stall_cnt_d = ld_stall_cnt_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_regwrite_q  <= 1'b0;
         wb_rd_data_q   <= '0;
         wb_rd_addr_q   <= '0;
         ld_funct3_q    <= '0;
         ld_addr_lo_q   <= '0;
         ld_rd_q        <= '0;
         ld_regwrite_q  <= 1'b0;
         ld_stall_cnt_q <= '0;
      end else begin
         wb_regwrite_q  <= wb_regwrite_d;
         wb_rd_data_q   <= wb_rd_data_d;
         wb_rd_addr_q   <= wb_rd_addr_d;
         ld_funct3_q    <= ld_funct3_d;
         ld_addr_lo_q   <= ld_addr_lo_d;
         ld_rd_q        <= ld_rd_d;
         ld_regwrite_q  <= ld_regwrite_d;
         ld_stall_cnt_q <= ld_stall_cnt_d;
      end
   end

   assign wb_regwrite  = wb_regwrite_q;
   assign wb_rd_data   = wb_rd_data_q;
   assign wb_rd_addr   = wb_rd_addr_q;
   assign ld_stall_cnt = ld_stall_cnt_q;

endmodule

// File: tb/tb_wb_load_stage.sv
// Bench for wb_load_stage: directed scenarios then random traffic, all
// checked against a transaction-level model of the stage.
module tb_wb_load_stage;
   import wb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   wb_load_stage_if #(.XLEN(32), .RA_W(5)) mem_if ();

   logic [31:0] dmem_rdata;
   logic        dmem_rvalid;
   logic        flush;
   logic        wb_regwrite;
   logic [31:0] wb_rd_data;
   logic [4:0]  wb_rd_addr;
   logic [31:0] ld_stall_cnt;

   wb_load_stage #(.XLEN(32), .RA_W(5), .CNT_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_if       (mem_if),
      .dmem_rdata   (dmem_rdata),
      .dmem_rvalid  (dmem_rvalid),
      .flush        (flush),
      .wb_regwrite  (wb_regwrite),
      .wb_rd_data   (wb_rd_data),
      .wb_rd_addr   (wb_rd_addr),
      .ld_stall_cnt (ld_stall_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // stimulus for the next cycle
   logic        s_valid, s_rw, s_rvalid, s_flush;
   logic [1:0]  s_sel;
   logic [2:0]  s_f3, s_alo;
   logic [31:0] s_alu, s_pc4, s_csr, s_rdata;
   logic [4:0]  s_rd;

   // reference model: a pending load record plus a "drop next rvalid" flag
   logic        m_pend, m_drain, m_rw, p_rw;
   logic [2:0]  p_f3, p_alo;
   logic [4:0]  p_rd, m_addr;
   logic [31:0] m_data, m_cnt;
   logic        last_ready;

   function automatic logic [31:0] ref_align(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [2:0] a);
      int unsigned bsh, hsh;
      logic [31:0] b, h;
      bsh = (int'(a) % 4) * 8;
      hsh = ((int'(a) / 2) % 2) * 16;
      b = (w >> bsh) & 32'hFF;
      h = (w >> hsh) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   function automatic logic m_ready();
      return !m_pend && !m_drain;
   endfunction

   task automatic model_reset();
      m_pend = 0; m_drain = 0; m_rw = 0; p_rw = 0;
      p_f3 = 0; p_alo = 0; p_rd = 0; m_addr = 0; m_data = 0; m_cnt = 0;
   endtask

   task automatic bump();
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
   endtask

   task automatic model_step();
      m_rw = 0;
      if (m_ready()) begin
         if (s_valid && !s_flush) begin
            if (s_sel == 2'd1) begin
               m_pend = 1; p_f3 = s_f3; p_alo = s_alo; p_rd = s_rd; p_rw = s_rw;
            end else begin
               m_data = (s_sel == 2'd2) ? s_pc4 : (s_sel == 2'd3) ? s_csr : s_alu;
               m_addr = s_rd;
               m_rw   = s_rw && (s_rd != 0);
            end
         end
      end else if (m_pend) begin
         if (s_rvalid) begin
            m_pend = 0;
            if (!s_flush) begin
               m_data = ref_align(s_rdata, p_f3, p_alo);
               m_addr = p_rd;
               m_rw   = p_rw && (p_rd != 0);
            end
         end else begin
            if (s_flush) begin m_pend = 0; m_drain = 1; end
            bump();
         end
      end else begin
         if (s_rvalid) m_drain = 0;
         else          bump();
      end
   endtask

   task automatic clr_stim();
      s_valid = 0; s_rw = 0; s_rvalid = 0; s_flush = 0; s_sel = 0; s_f3 = 0; s_alo = 0;
      s_alu = 0; s_pc4 = 0; s_csr = 0; s_rdata = 0; s_rd = 0;
   endtask

   task automatic drive();
      mem_if.mem_valid    = s_valid;
      mem_if.mem_regwrite = s_rw;
      mem_if.mem_rd_sel   = rd_sel_e'(s_sel);
      mem_if.mem_funct3   = s_f3;
      mem_if.mem_addr_lo  = s_alo;
      mem_if.mem_alu      = s_alu;
      mem_if.mem_pc4      = s_pc4;
      mem_if.mem_csr      = s_csr;
      mem_if.mem_rd_addr  = s_rd;
      dmem_rdata          = s_rdata;
      dmem_rvalid         = s_rvalid;
      flush               = s_flush;
   endtask

   // called just after a rising edge: drive, step model, check after next edge
   task automatic run_cycle();
      drive();
      #1;
      last_ready = mem_if.mem_ready;
      check_val("mem_ready", 32'(last_ready), 32'(m_ready()));
      model_step();
      @(posedge clk);
      #1;
      check_val("wb_regwrite", 32'(wb_regwrite), 32'(m_rw));
      check_val("wb_rd_data", wb_rd_data, m_data);
      check_val("wb_rd_addr", 32'(wb_rd_addr), 32'(m_addr));
      check_val("ld_stall_cnt", ld_stall_cnt, m_cnt);
   endtask

   task automatic issue_load(input logic [2:0] f3, input logic [2:0] alo, input logic [4:0] rd);
      clr_stim();
      s_valid = 1; s_rw = 1; s_sel = 2'd1; s_f3 = f3; s_alo = alo; s_rd = rd;
      run_cycle();
   endtask

   initial begin
      int ready_low;
      logic wrote;

      clr_stim();
      drive();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_regwrite", 32'(wb_regwrite), 32'd0);
      check_val("rst_rd_data", wb_rd_data, 32'd0);
      check_val("rst_rd_addr", 32'(wb_rd_addr), 32'd0);
      check_val("rst_stall_cnt", ld_stall_cnt, 32'd0);
      check_val("rst_mem_ready", 32'(mem_if.mem_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // ALU op
      clr_stim();
      s_valid = 1; s_rw = 1; s_sel = 2'd0; s_alu = 32'h1234; s_rd = 5'd5;
      run_cycle();
      check_val("alu_regwrite", 32'(wb_regwrite), 32'd1);
      check_val("alu_data", wb_rd_data, 32'h1234);
      check_val("alu_addr", 32'(wb_rd_addr), 32'd5);
      clr_stim();
      run_cycle();
      check_val("alu_pulse", 32'(wb_regwrite), 32'd0);
      check_val("alu_hold", wb_rd_data, 32'h1234);

      // LB, rvalid on the third wait cycle
      issue_load(3'd0, 3'd1, 5'd7);
      ready_low = 0;
      for (int i = 0; i < 3; i++) begin
         clr_stim();
         if (i == 2) begin s_rvalid = 1; s_rdata = 32'h80FF_7F01; end
         run_cycle();
         if (!last_ready) ready_low++;
      end
      check_val("lb_data", wb_rd_data, 32'h0000_007F);
      check_val("lb_stall", ld_stall_cnt, 32'd2);
      check_val("lb_ready_low", 32'(ready_low), 32'd3);

      // LHU / LH with immediate data
      issue_load(3'd5, 3'd2, 5'd8);
      clr_stim(); s_rvalid = 1; s_rdata = 32'h80FF_7F01;
      run_cycle();
      check_val("lhu_data", wb_rd_data, 32'h0000_80FF);
      issue_load(3'd1, 3'd2, 5'd8);
      clr_stim(); s_rvalid = 1; s_rdata = 32'h80FF_7F01;
      run_cycle();
      check_val("lh_data", wb_rd_data, 32'hFFFF_80FF);

      // PC4 to x0
      clr_stim();
      s_valid = 1; s_rw = 1; s_sel = 2'd2; s_pc4 = 32'h100; s_rd = 5'd0;
      run_cycle();
      check_val("x0_regwrite", 32'(wb_regwrite), 32'd0);
      check_val("x0_data", wb_rd_data, 32'h100);

      // flush in WAIT_LD, rvalid two cycles later is dropped
      issue_load(3'd2, 3'd0, 5'd9);
      wrote = 0;
      clr_stim(); s_flush = 1;
      run_cycle(); wrote |= wb_regwrite;
      clr_stim();
      run_cycle(); wrote |= wb_regwrite;
      check_val("drain_ready", 32'(last_ready), 32'd0);
      clr_stim(); s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
      run_cycle(); wrote |= wb_regwrite;
      check_val("flush_nowrite", 32'(wrote), 32'd0);
      check_val("flush_data", wb_rd_data, 32'h100);
      clr_stim();
      run_cycle();
      check_val("flush_ready", 32'(last_ready), 32'd1);

      // reset during WAIT_LD, then a stale rvalid
      issue_load(3'd2, 3'd0, 5'd3);
      clr_stim();
      run_cycle();
      rst = 1'b0;
      #1;
      check_val("mid_rst_data", wb_rd_data, 32'd0);
      check_val("mid_rst_cnt", ld_stall_cnt, 32'd0);
      check_val("mid_rst_ready", 32'(mem_if.mem_ready), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      clr_stim(); s_rvalid = 1; s_rdata = 32'h55;
      run_cycle();
      check_val("post_rst_regwrite", 32'(wb_regwrite), 32'd0);
      check_val("post_rst_data", wb_rd_data, 32'd0);
      check_val("post_rst_addr", 32'(wb_rd_addr), 32'd0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         s_valid  = ($urandom_range(0, 3) != 0);
         s_rw     = 1'($urandom_range(0, 1));
         s_sel    = 2'($urandom_range(0, 3));
         s_f3     = 3'($urandom_range(0, 7));
         s_alo    = 3'($urandom_range(0, 7));
         s_alu    = $urandom;
         s_pc4    = $urandom;
         s_csr    = $urandom;
         s_rdata  = $urandom;
         s_rd     = 5'($urandom_range(0, 31));
         s_rvalid = ($urandom_range(0, 2) == 0);
         s_flush  = ($urandom_range(0, 9) == 0);
         run_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wb_load_stage.md
WB_LOAD_STAGE -- requirements
Module: wb_load_stage

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning datapath width (32 or 64).
REQ-002 The module SHALL have parameter RA_W, default 5, meaning register address width.
REQ-003 The module SHALL have parameter CNT_W, default 32, meaning load-stall counter width.
REQ-004 The module SHALL have a single clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- mem_valid  in  1  MEM stage presents an instruction.
- mem_ready  out  1  stage can accept.
- mem_regwrite  in  1  instruction writes rd.
- mem_rd_sel  in  2  result source: 0 ALU, 1 LOAD, 2 PC4, 3 CSR.
- mem_funct3  in  3  load size/sign.
- mem_addr_lo  in  3  low address bits of the load.
- mem_alu  in  XLEN  ALU result.
- mem_pc4  in  XLEN  PC+4.
- mem_csr  in  XLEN  CSR read data.
- mem_rd_addr  in  RA_W  destination register.
- dmem_rdata  in  XLEN  data-memory read word.
- dmem_rvalid  in  1  dmem_rdata valid this cycle.
- flush  in  1  cancel the pending instruction.
- wb_regwrite  out  1  register-file write strobe.
- wb_rd_data  out  XLEN  write data.
- wb_rd_addr  out  RA_W  write address.
- ld_stall_cnt  out  CNT_W  cycles spent waiting for load data.

Function
REQ-005 The FSM SHALL have states IDLE, WAIT_LD and DRAIN.
REQ-006 mem_ready SHALL be 1 only in IDLE, and 0 during reset.
REQ-007 An instruction SHALL be accepted only when mem_valid and mem_ready are both 1.
REQ-008 An accepted non-load (rd_sel != 1) SHALL drive wb_regwrite, wb_rd_data and wb_rd_addr on the next cycle only, so latency is 1; the FSM stays in IDLE.
REQ-009 An accepted load SHALL latch funct3, addr_lo, rd_addr and regwrite, and SHALL move the FSM to WAIT_LD.
REQ-010 In WAIT_LD, dmem_rvalid=1 SHALL register the aligned data, drive wb_regwrite on the next cycle, and return the FSM to IDLE.
REQ-011 A new instruction SHALL NOT be accepted in the cycle that rvalid arrives.
REQ-012 Load alignment SHALL be:
- LB/LBU select byte addr_lo, sign/zero extend.
- LH/LHU select halfword addr_lo[2:1], sign/zero extend.
- LW selects word addr_lo[2], sign extended when XLEN=64.
- LWU zero-extends the word.
- LD passes the full word.
- Any other funct3 is treated as LW/LD at XLEN width.
REQ-013 wb_regwrite SHALL be forced to 0 when the destination is x0 or regwrite=0, while wb_rd_data still updates.
REQ-014 wb_regwrite SHALL be a single-cycle pulse; wb_rd_data and wb_rd_addr SHALL hold their values until the next write.
REQ-015 flush in IDLE SHALL suppress the write of an instruction accepted in the same cycle.
REQ-016 flush in WAIT_LD without rvalid SHALL move the FSM to DRAIN with no write.
REQ-017 flush in WAIT_LD with rvalid in the same cycle SHALL move the FSM to IDLE and discard the data.
REQ-018 DRAIN SHALL keep mem_ready=0, discard the next rvalid, and then return to IDLE; flush in DRAIN SHALL be ignored.
REQ-019 ld_stall_cnt SHALL increment every cycle spent in WAIT_LD or DRAIN without rvalid, and SHALL saturate at all-ones.
REQ-020 dmem_rvalid in IDLE SHALL be ignored.

Reset
REQ-021 On rst=0, asynchronously: FSM to IDLE; wb_regwrite 0; wb_rd_data 0; wb_rd_addr 0; ld_stall_cnt 0; all latched load fields 0.
REQ-022 Reset asserted mid-load SHALL abandon the load; an rvalid arriving after reset release SHALL be ignored per REQ-020.

Structure
REQ-023 Package wb_pkg SHALL hold the rd_sel enum, the funct3 load constants and the FSM state enum.
REQ-024 Sub-module load_align SHALL be combinational and parametrised by XLEN, with inputs word, funct3 and addr_lo and output aligned data.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- ALU op: alu=0x1234, rd=5 -> next cycle wb_regwrite=1, data=0x1234, addr=5.
- LB: rdata=0x80FF7F01, addr_lo=1, rvalid after 3 cycles -> data=0x0000007F, ld_stall_cnt=2, mem_ready low 3 cycles.
- LHU: rdata=0x80FF7F01, addr_lo=2 -> data=0x000080FF; LH gives 0xFFFF80FF.
- rd=0 PC4 op -> wb_regwrite stays 0, wb_rd_data=pc4.
- Flush in WAIT_LD, rvalid 2 cycles later -> FSM goes to DRAIN, no write, then IDLE, mem_ready=1.
- rst low during WAIT_LD, then rvalid -> no write, all outputs 0.
